// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e       : controller states (IDLE, RUN, DONE)
//   MODE_ADD/SUB  : encoding of the 'sub' mode input
//   cnt_width()   : width of a counter that indexes n digits (at least 1 bit)
//   full_add()    : one-bit full-adder cell, returns {carry, sum}
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// DIGIT-bit ripple-carry adder made of one-bit full-adder cells. Purely
// combinational.
//   x, y : DIGIT-bit addends
//   cin  : carry in
//   sum  : DIGIT-bit sum
//   cout : carry out of the top bit
module digit_adder
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < DIGIT; i++) begin
            {carry, sum[i]} = full_add(x[i], y[i], carry);
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands
// DIGIT bits per clock through one narrow carry chain.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (s, c_out, ovf)
//   s                   : sum/difference, modulo 2^WIDTH
//   c_out               : carry out of MSB (subtract: 1 = no borrow)
//   ovf                 : two's-complement signed overflow
//   dbg_state           : current controller state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and s/c_out/ovf hold steady until out_ready is seen. in_valid outside
// IDLE is ignored.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output state_e           dbg_state
);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_addsub: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
    end

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;

    logic [WIDTH-1:0]   b_eff;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;

    assign b_eff = (sub == MODE_SUB) ? ~b : b;

    // Operands are shifted right each RUN cycle, so the current digit always
    // sits in the low DIGIT bits.
    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    carry_d = sub;        // +1 completes the two's complement of b
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // New digit enters at the top; after NDIG cycles digit 0 has
                // reached the bottom and s_q holds the full result.
                s_d     = WIDTH'({dig_sum, s_q} >> DIGIT);
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign s         = s_q;
    assign c_out     = carry_q;
    assign ovf       = (a_msb_q == b_msb_q) && (s_q[WIDTH-1] != a_msb_q);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  // Configurations: 0 = 16/4, 1 = 16/1, 2 = 16/16, 3 = 8/2
  logic clk;
  logic rst_n;
  logic        iv     [4];
  logic [15:0] a_in   [4];
  logic [15:0] b_in   [4];
  logic        sub_in [4];
  logic        or_in  [4];

  logic ir0, ir1, ir2, ir3;
  logic ov0, ov1, ov2, ov3;
  logic co0, co1, co2, co3;
  logic of0, of1, of2, of3;
  logic [15:0] s0, s1, s2;
  logic [7:0]  s3;
  state_e dbg0, dbg1, dbg2, dbg3;

  int n_checks = 0;
  int n_fails  = 0;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .a(a_in[0]), .b(b_in[0]),
    .sub(sub_in[0]), .out_valid(ov0), .out_ready(or_in[0]), .s(s0), .c_out(co0), .ovf(of0),
    .dbg_state(dbg0));
  serial_addsub #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .a(a_in[1]), .b(b_in[1]),
    .sub(sub_in[1]), .out_valid(ov1), .out_ready(or_in[1]), .s(s1), .c_out(co1), .ovf(of1),
    .dbg_state(dbg1));
  serial_addsub #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .a(a_in[2]), .b(b_in[2]),
    .sub(sub_in[2]), .out_valid(ov2), .out_ready(or_in[2]), .s(s2), .c_out(co2), .ovf(of2),
    .dbg_state(dbg2));
  serial_addsub #(.WIDTH(8), .DIGIT(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir3), .a(a_in[3][7:0]),
    .b(b_in[3][7:0]), .sub(sub_in[3]), .out_valid(ov3), .out_ready(or_in[3]), .s(s3),
    .c_out(co3), .ovf(of3), .dbg_state(dbg3));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic rd(input int cfg, output logic ir_o, output logic ov_o, output logic [15:0] s_o,
                    output logic c_o, output logic of_o, output state_e st_o);
    case (cfg)
      0: begin ir_o = ir0; ov_o = ov0; s_o = s0; c_o = co0; of_o = of0; st_o = dbg0; end
      1: begin ir_o = ir1; ov_o = ov1; s_o = s1; c_o = co1; of_o = of1; st_o = dbg1; end
      2: begin ir_o = ir2; ov_o = ov2; s_o = s2; c_o = co2; of_o = of2; st_o = dbg2; end
      default: begin ir_o = ir3; ov_o = ov3; s_o = {8'h00, s3}; c_o = co3; of_o = of3; st_o = dbg3; end
    endcase
  endtask

  function automatic int cfg_width(input int cfg);
    return (cfg == 3) ? 8 : 16;
  endfunction

  function automatic int cfg_ndig(input int cfg);
    case (cfg)
      0: return 4;
      1: return 16;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  // Reference: plain integer arithmetic, returns {ovf, c_out, s}.
  function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic sv);
    longint mask, ua, ub, sa, sb, sr, ur, lo, hi;
    logic [63:0] r64;
    logic c, ov;
    mask = (64'sd1 <<< w) - 1;
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    sa = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
    sb = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
    sr = sv ? sa - sb : sa + sb;
    ur = sv ? ua - ub : ua + ub;
    c  = sv ? (ua >= ub) : (ur > mask);
    lo = -(64'sd1 <<< (w - 1));
    hi = (64'sd1 <<< (w - 1)) - 1;
    ov = (sr < lo) || (sr > hi);
    r64 = 64'(ur & mask);
    return {ov, c, r64[15:0]};
  endfunction

  // ---------------- driver ----------------
  // Entered and left at posedge+#1. Issues one op with out_ready high,
  // scrambles the inputs right after the accept edge, and reports result,
  // latency in edges after accept, and the handshake state one cycle later.
  task automatic do_op(input int cfg, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       output logic [15:0] gs, output logic gc, output logic go, output int lat,
                       output logic ov_after, output logic ir_after);
    logic ir_l, ov_l, c_l, of_l;
    logic [15:0] s_l;
    state_e st_l;
    int n;
    n = 0;
    rd(cfg, ir_l, ov_l, s_l, c_l, of_l, st_l);
    while (!ir_l && n < 50) begin
      @(posedge clk); #1; n++;
      rd(cfg, ir_l, ov_l, s_l, c_l, of_l, st_l);
    end
    if (!ir_l) chk($sformatf("cfg%0d_in_ready_timeout", cfg), 32'(ir_l), 32'd1);
    or_in[cfg] = 1'b1;
    a_in[cfg] = av; b_in[cfg] = bv; sub_in[cfg] = sv; iv[cfg] = 1'b1;
    @(posedge clk); #1;
    iv[cfg] = 1'b0;
    a_in[cfg] = 16'($urandom); b_in[cfg] = 16'($urandom); sub_in[cfg] = 1'($urandom);
    lat = 0;
    rd(cfg, ir_l, ov_l, s_l, c_l, of_l, st_l);
    while (!ov_l && lat < 100) begin
      @(posedge clk); #1; lat++;
      rd(cfg, ir_l, ov_l, s_l, c_l, of_l, st_l);
    end
    gs = s_l; gc = c_l; go = of_l;
    @(posedge clk); #1;
    rd(cfg, ir_l, ov_l, s_l, c_l, of_l, st_l);
    ov_after = ov_l; ir_after = ir_l;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        ov;
  } vec_t;

  vec_t tbl[6];

  // ---------------- test ----------------
  initial begin
    logic ir_l, ov_l, c_l, of_l, ov_a, ir_a;
    logic [15:0] s_l;
    logic [17:0] exp;
    state_e st_l;
    int lat, n, w;
    logic [15:0] av, bv, msk;
    logic sv;

    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      iv[c] = 1'b0; a_in[c] = '0; b_in[c] = '0; sub_in[c] = 1'b0; or_in[c] = 1'b1;
    end

    // Reset values on every configuration
    #12;
    for (int c = 0; c < 4; c++) begin
      rd(c, ir_l, ov_l, s_l, c_l, of_l, st_l);
      chk($sformatf("cfg%0d_rst_in_ready", c), 32'(ir_l), 32'd1);
      chk($sformatf("cfg%0d_rst_out_valid", c), 32'(ov_l), 32'd0);
      chk($sformatf("cfg%0d_rst_s", c), 32'(s_l), 32'd0);
      chk($sformatf("cfg%0d_rst_c_out", c), 32'(c_l), 32'd0);
      chk($sformatf("cfg%0d_rst_ovf", c), 32'(of_l), 32'd0);
      chk($sformatf("cfg%0d_rst_state", c), 32'(st_l), 32'(IDLE));
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table on 16/4
    for (int i = 0; i < 6; i++) begin
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].sub, s_l, c_l, of_l, lat, ov_a, ir_a);
      chk($sformatf("vec%0d_s", i), 32'(s_l), 32'(tbl[i].s));
      chk($sformatf("vec%0d_c_out", i), 32'(c_l), 32'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(of_l), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_valid_one_cycle", i), 32'(ov_a), 32'd0);
      chk($sformatf("vec%0d_ready_after", i), 32'(ir_a), 32'd1);
    end

    // Backpressure: hold result for 5 cycles, ignore a pulsed in_valid
    or_in[0] = 1'b0;
    a_in[0] = 16'h1234; b_in[0] = 16'h1111; sub_in[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 0;
    rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
    while (!ov_l && n < 50) begin
      @(posedge clk); #1; n++;
      rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
    end
    chk("bp_out_valid", 32'(ov_l), 32'd1);
    chk("bp_s", 32'(s_l), 32'h2345);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        iv[0] = 1'b1; a_in[0] = 16'h1111; b_in[0] = 16'h1111;
      end
      @(posedge clk); #1;
      iv[0] = 1'b0;
      rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
      chk($sformatf("bp_hold%0d_s", k), 32'(s_l), 32'h2345);
      chk($sformatf("bp_hold%0d_c_out", k), 32'(c_l), 32'd0);
      chk($sformatf("bp_hold%0d_ovf", k), 32'(of_l), 32'd0);
      chk($sformatf("bp_hold%0d_in_ready", k), 32'(ir_l), 32'd0);
      chk($sformatf("bp_hold%0d_out_valid", k), 32'(ov_l), 32'd1);
    end
    or_in[0] = 1'b1;
    @(posedge clk); #1;
    rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
    chk("bp_release_out_valid", 32'(ov_l), 32'd0);
    chk("bp_release_in_ready", 32'(ir_l), 32'd1);
    do_op(0, 16'h0F0F, 16'h0101, 1'b1, s_l, c_l, of_l, lat, ov_a, ir_a);
    chk("bp_next_s", 32'(s_l), 32'h0E0E);
    chk("bp_next_c_out", 32'(c_l), 32'd1);
    chk("bp_next_ovf", 32'(of_l), 32'd0);
    chk("bp_next_latency", 32'(lat), 32'd4);

    // Reset in the middle of RUN, after two digit edges
    a_in[0] = 16'hABCD; b_in[0] = 16'h1111; sub_in[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
    chk("midrst_out_valid", 32'(ov_l), 32'd0);
    chk("midrst_in_ready", 32'(ir_l), 32'd1);
    chk("midrst_s", 32'(s_l), 32'd0);
    chk("midrst_c_out", 32'(c_l), 32'd0);
    chk("midrst_ovf", 32'(of_l), 32'd0);
    chk("midrst_state", 32'(st_l), 32'(IDLE));
    repeat (3) begin
      @(posedge clk); #1;
      rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
      chk("midrst_hold_out_valid", 32'(ov_l), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    rd(0, ir_l, ov_l, s_l, c_l, of_l, st_l);
    chk("postrst_in_ready", 32'(ir_l), 32'd1);
    chk("postrst_out_valid", 32'(ov_l), 32'd0);
    do_op(0, 16'h1234, 16'h4321, 1'b0, s_l, c_l, of_l, lat, ov_a, ir_a);
    chk("postrst_s", 32'(s_l), 32'h5555);
    chk("postrst_c_out", 32'(c_l), 32'd0);
    chk("postrst_ovf", 32'(of_l), 32'd0);
    chk("postrst_latency", 32'(lat), 32'd4);

    // Random sweep on every configuration against the reference model
    for (int c = 0; c < 4; c++) begin
      w = cfg_width(c);
      msk = (w == 8) ? 16'h00FF : 16'hFFFF;
      for (int i = 0; i < 1000; i++) begin
        case ($urandom_range(0, 7))
          0: av = msk;
          1: av = (w == 8) ? 16'h0080 : 16'h8000;
          2: av = '0;
          default: av = 16'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0: bv = msk;
          1: bv = (w == 8) ? 16'h0080 : 16'h8000;
          2: bv = '0;
          default: bv = 16'($urandom);
        endcase
        av = av & msk;
        bv = bv & msk;
        sv = 1'($urandom_range(0, 1));
        exp = model(w, av, bv, sv);
        do_op(c, av, bv, sv, s_l, c_l, of_l, lat, ov_a, ir_a);
        chk($sformatf("cfg%0d_rnd%0d_s a=%0h b=%0h sub=%0d", c, i, av, bv, sv), 32'(s_l), 32'(exp[15:0]));
        chk($sformatf("cfg%0d_rnd%0d_c_out", c, i), 32'(c_l), 32'(exp[16]));
        chk($sformatf("cfg%0d_rnd%0d_ovf", c, i), 32'(of_l), 32'(exp[17]));
        chk($sformatf("cfg%0d_rnd%0d_latency", c, i), 32'(lat), 32'(cfg_ndig(c)));
        chk($sformatf("cfg%0d_rnd%0d_valid_one_cycle", c, i), 32'(ov_a), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
